// File: rtl/reaction_bcd_timer.sv
// reaction_bcd_timer
// Reaction-timer measurement core: random foreperiod, stimulus LED, then a
// four-digit BCD millisecond count that freezes on the player's stop press.
// A stop before the LED is a false start. The count saturates at 9999.

module reaction_bcd_timer #(
    parameter int TICK_DIV    = 100000, // clock cycles per 1 ms tick, >= 2
    parameter int MIN_WAIT_MS = 1000,   // fixed foreperiod part, 1..32767
    parameter int RAND_BITS   = 11      // random extension width, <= 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] thousand,
    output logic [3:0] hund,
    output logic [3:0] ten,
    output logic [3:0] unit,
    output logic       led,
    output logic       early,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DONE
    } state_t;

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]     MIN_WAIT   = 16'(MIN_WAIT_MS);
    localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

    state_t        state_q, state_d;
    logic          start_q, stop_q;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   wait_q, wait_d;
    logic [3:0]    thou_q, thou_d;
    logic [3:0]    hund_q, hund_d;
    logic [3:0]    ten_q, ten_d;
    logic [3:0]    unit_q, unit_d;
    logic          led_q, led_d;
    logic          early_q, early_d;
    logic          busy_q, busy_d;

    logic          start_rise, stop_rise, tick;
    logic          u9, t9, h9, all_nines;
    logic [3:0]    thou_inc, hund_inc, ten_inc, unit_inc;
    logic [15:0]   rand_ext;

    // Rises only: a held button acts once and must drop before it can retrigger.
    assign start_rise = start & ~start_q;
    assign stop_rise  = stop & ~stop_q;

    // Prescaler wraps on the tick, so the tick itself is just the last count.
    assign tick = (presc_q == PRESC_LAST);

    // Fibonacci LFSR, taps 16,14,13,11; a nonzero seed keeps it off all-zero.
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign rand_ext = {{(16 - RAND_BITS){1'b0}}, lfsr_q[RAND_BITS-1:0]};

    // BCD ripple increment; each digit rolls only when every lower digit is 9.
    assign u9        = (unit_q == 4'd9);
    assign t9        = (ten_q == 4'd9);
    assign h9        = (hund_q == 4'd9);
    assign all_nines = u9 & t9 & h9 & (thou_q == 4'd9);
    assign unit_inc  = u9 ? 4'd0 : unit_q + 4'd1;
    assign ten_inc   = !u9 ? ten_q : (t9 ? 4'd0 : ten_q + 4'd1);
    assign hund_inc  = !(u9 & t9) ? hund_q : (h9 ? 4'd0 : hund_q + 4'd1);
    assign thou_inc  = !(u9 & t9 & h9) ? thou_q : thou_q + 4'd1;

    // Next-state and datapath: stop rises take priority over ticks in WAIT/RUN.
    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        wait_d  = wait_q;
        thou_d  = thou_q;
        hund_d  = hund_q;
        ten_d   = ten_q;
        unit_d  = unit_q;
        led_d   = led_q;
        early_d = early_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_rise) begin
                    state_d = S_WAIT;
                    presc_d = '0;
                    wait_d  = MIN_WAIT + rand_ext;
                    thou_d  = 4'd0;
                    hund_d  = 4'd0;
                    ten_d   = 4'd0;
                    unit_d  = 4'd0;
                    led_d   = 1'b0;
                    early_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (stop_rise) begin
                    state_d = S_DONE;
                    early_d = 1'b1;
                end else if (tick) begin
                    wait_d = wait_q - 16'd1;
                    if (wait_q == 16'd1) begin
                        state_d = S_RUN;
                        led_d   = 1'b1;
                        presc_d = '0;
                    end
                end
            end
            S_RUN: begin
                if (stop_rise) begin
                    state_d = S_DONE;
                    led_d   = 1'b0;
                end else if (tick) begin
                    if (all_nines) begin
                        // Saturate: the display holds 9999 and the trial ends.
                        state_d = S_DONE;
                        led_d   = 1'b0;
                    end else begin
                        thou_d = thou_inc;
                        hund_d = hund_inc;
                        ten_d  = ten_inc;
                        unit_d = unit_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_WAIT) || (state_d == S_RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            presc_q <= '0;
            wait_q  <= 16'd0;
            thou_q  <= 4'd0;
            hund_q  <= 4'd0;
            ten_q   <= 4'd0;
            unit_q  <= 4'd0;
            led_q   <= 1'b0;
            early_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            stop_q  <= stop;
            lfsr_q  <= lfsr_d;
            presc_q <= presc_d;
            wait_q  <= wait_d;
            thou_q  <= thou_d;
            hund_q  <= hund_d;
            ten_q   <= ten_d;
            unit_q  <= unit_d;
            led_q   <= led_d;
            early_q <= early_d;
            busy_q  <= busy_d;
        end
    end

    assign thousand = thou_q;
    assign hund     = hund_q;
    assign ten      = ten_q;
    assign unit     = unit_q;
    assign led      = led_q;
    assign early    = early_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_reaction_bcd_timer.sv
// Bench for reaction_bcd_timer: table vectors, directed multi-cycle corners,
// and randomized traffic compared each cycle against a behavioural model that
// tracks elapsed cycles per trial and derives ms counts by division.

module tb_reaction_bcd_timer;

    localparam int TD   = 4;
    localparam int MINW = 3;
    localparam int RB   = 2;

    localparam int M_IDLE = 0, M_WAIT = 1, M_RUN = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, start = 1'b0, stop = 1'b0;
    logic [3:0] thousand, hund, ten, unit;
    logic       led, early, busy;

    reaction_bcd_timer #(.TICK_DIV(TD), .MIN_WAIT_MS(MINW), .RAND_BITS(RB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .thousand(thousand), .hund(hund), .ten(ten), .unit(unit),
        .led(led), .early(early), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: elapsed cycles since trial-phase entry, count = elapsed/TD.
    int          m_mode, m_el, m_wait, m_cnt;
    bit          m_led, m_early, m_ps, m_pt;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] bcd4(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function void model_reset();
        m_mode = M_IDLE; m_el = 0; m_wait = 0; m_cnt = 0;
        m_led = 0; m_early = 0; m_ps = 0; m_pt = 0;
        m_lfsr = 16'hACE1;
    endfunction

    function void model_step(bit r, bit s, bit t);
        bit sr, tr;
        if (!r) begin
            model_reset();
            return;
        end
        sr = s && !m_ps;
        tr = t && !m_pt;
        case (m_mode)
            M_IDLE, M_DONE: if (sr) begin
                m_mode = M_WAIT; m_el = 0; m_cnt = 0; m_led = 0; m_early = 0;
                m_wait = MINW + int'(m_lfsr % (1 << RB));
            end
            M_WAIT: if (tr) begin
                m_mode = M_DONE; m_early = 1;
            end else begin
                m_el++;
                if (m_el == m_wait * TD) begin
                    m_mode = M_RUN; m_led = 1; m_el = 0;
                end
            end
            M_RUN: if (tr) begin
                m_mode = M_DONE; m_led = 0;
            end else begin
                m_el++;
                if (m_el == 10000 * TD) begin
                    m_mode = M_DONE; m_led = 0; m_cnt = 9999;
                end else begin
                    m_cnt = m_el / TD;
                end
            end
            default: ;
        endcase
        m_ps = s;
        m_pt = t;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {thousand, hund, ten, unit, led, early, busy};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare 1 time unit later.
    task automatic cyc(bit r, bit s, bit t);
        logic [18:0] exp;
        @(negedge clk);
        rst_n = r; start = s; stop = t;
        @(posedge clk);
        model_step(r, s, t);
        #1;
        exp = {bcd4(m_cnt), m_led, m_early, (m_mode == M_WAIT || m_mode == M_RUN)};
        chk("cycle", 32'(dut_vec()), 32'(exp));
    endtask

    task automatic wait_led(int budget, output int n);
        n = 0;
        while (led !== 1'b1 && n < budget) begin
            cyc(1, 0, 0);
            n++;
        end
        chk("led_rise_in_budget", 32'(led), 32'd1);
    endtask

    // Full trial: start pulse, stop sampled K ticks after the led edge.
    task automatic trial(int k);
        int n;
        cyc(1, 1, 0);
        wait_led(200, n);
        chk("foreperiod", 32'(n), 32'(m_wait * TD));
        for (int i = 0; i < TD * k; i++) cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("trial_digits", 32'({thousand, hund, ten, unit}), 32'(bcd4(k)));
        chk("trial_led_early", 32'({led, early, busy}), 32'b000);
        cyc(1, 0, 0);
    endtask

    typedef struct packed {
        logic r, s, t;
        logic e_early, e_busy;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n, rises;
        bit prev_busy;
        model_reset();

        // Reset and idle: everything zero, busy low.
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 0, 0);
        chk("idle_outputs", 32'(dut_vec()), 32'd0);

        // Table: stop ignored in IDLE, start wins over stop, false start, held
        // levels, start from DONE, reset out of WAIT.
        tbl[0]  = '{r:0, s:0, t:0, e_early:0, e_busy:0};
        tbl[1]  = '{r:1, s:0, t:1, e_early:0, e_busy:0};
        tbl[2]  = '{r:1, s:0, t:0, e_early:0, e_busy:0};
        tbl[3]  = '{r:1, s:1, t:1, e_early:0, e_busy:1};
        tbl[4]  = '{r:1, s:1, t:1, e_early:0, e_busy:1};
        tbl[5]  = '{r:1, s:0, t:0, e_early:0, e_busy:1};
        tbl[6]  = '{r:1, s:0, t:1, e_early:1, e_busy:0};
        tbl[7]  = '{r:1, s:0, t:1, e_early:1, e_busy:0};
        tbl[8]  = '{r:1, s:1, t:0, e_early:0, e_busy:1};
        tbl[9]  = '{r:0, s:0, t:0, e_early:0, e_busy:0};
        tbl[10] = '{r:1, s:0, t:1, e_early:0, e_busy:0};
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].r, tbl[i].s, tbl[i].t);
            chk($sformatf("vec%0d", i), 32'(dut_vec()),
                32'({16'h0000, 1'b0, tbl[i].e_early, tbl[i].e_busy}));
        end
        cyc(1, 0, 0);

        // Normal trials.
        trial(123);
        for (int i = 0; i < 4; i++) trial($urandom_range(0, 30));

        // False start on the cycle of the final WAIT tick.
        cyc(1, 1, 0);
        n = 0;
        while (m_mode == M_WAIT && m_el + 1 != m_wait * TD && n < 200) begin
            cyc(1, 0, 0);
            n++;
        end
        cyc(1, 0, 1);
        chk("final_tick_false_start", 32'(dut_vec()), 32'({16'h0000, 1'b0, 1'b1, 1'b0}));
        for (int i = 0; i < 3 * TD; i++) begin
            cyc(1, 0, 0);
            chk("no_led_after_false_start", 32'(led), 32'd0);
        end

        // False start a few cycles into WAIT.
        cyc(1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("early_false_start", 32'(dut_vec()), 32'({16'h0000, 1'b0, 1'b1, 1'b0}));
        cyc(1, 0, 0);

        // From DONE with both held high: one trial that runs to saturation.
        cyc(1, 1, 1);
        chk("done_restart", 32'({thousand, hund, ten, unit, early, busy}), 32'({16'h0000, 1'b0, 1'b1}));
        rises = 1;
        prev_busy = 1;
        n = 0;
        while (m_mode != M_DONE && n < 45000) begin
            cyc(1, 1, 1);
            n++;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
            if (m_mode == M_RUN && m_el == 10 * TD)
                chk("bcd_0010", 32'({thousand, hund, ten, unit}), 32'h0010);
            if (m_mode == M_RUN && m_el == 100 * TD)
                chk("bcd_0100", 32'({thousand, hund, ten, unit}), 32'h0100);
            if (m_mode == M_RUN && m_el == 1000 * TD)
                chk("bcd_1000", 32'({thousand, hund, ten, unit}), 32'h1000);
        end
        chk("timeout_reached", 32'(dut_vec()), 32'({16'h9999, 1'b0, 1'b0, 1'b0}));
        for (int i = 0; i < 10 * TD; i++) begin
            cyc(1, 1, 1);
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        chk("timeout_hold", 32'(dut_vec()), 32'({16'h9999, 1'b0, 1'b0, 1'b0}));
        chk("single_trial", 32'(rises), 32'd1);
        cyc(1, 0, 0);

        // Reset mid-RUN at 0042, then a normal trial.
        cyc(1, 1, 0);
        n = 0;
        while ({thousand, hund, ten, unit} !== 16'h0042 && n < 500) begin
            cyc(1, 0, 0);
            n++;
        end
        chk("reached_0042", 32'({thousand, hund, ten, unit, led}), 32'({16'h0042, 1'b1}));
        cyc(0, 0, 0);
        chk("reset_mid_run", 32'(dut_vec()), 32'd0);
        cyc(1, 0, 0);
        trial(7);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++)
            cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 29) == 0), ($urandom_range(0, 14) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
